oam_dma_ctrl: RTL and testbench
===============================

// Module: oam_dma_ctrl
// PURPOSE
//  Sequences the NES sprite DMA ($4014): snoops the shared CPU memory bus for a write to the trigger
//  address and requests a CPU halt. Once halted, copies 256 bytes from page {P,8'h00}..{P,8'hFF} to
//  OAM data port $2004 as read/write pairs, then releases the CPU. Sits beside the system controller
//  on the CPU bus mux; the system controller always has priority.
// PARAMETERS
//  TRIG_ADDR      16'h4014  bus write address that starts a transfer; write data = source page P
//  OAM_DATA_ADDR  16'h2004  destination address of every write
//  XFER_LEN       256       bytes per transfer (power of 2, <=256)
//  HALT_TIMEOUT   1023      max cycles in S_HALT_REQ before abort with dma_err
// PORTS
//  clk            in   1   system clock
//  rst            in   1   reset, asynchronous, active-low
//  snoop_addr     in   16  post-mux CPU bus address
//  snoop_data     in   8   post-mux CPU bus write data
//  snoop_wr_en    in   1   post-mux CPU bus write strobe
//  cpu_is_halted  in   1   CPU has stopped driving the bus
//  ext_hold       in   1   system controller owns the bus (its mux ctrl); pauses DMA
//  dma_abort      in   1   synchronous abort request
//  dma_bus_data_in in  8   bus read data
//  cpu_halt       out  1   halt request, ORed externally with system-controller halt
//  dma_mux_ctrl   out  1   1 = DMA drives bus address/data/strobes
//  dma_bus_addr   out  16  bus address
//  dma_bus_data_out out 8  bus write data
//  dma_bus_read_en  out 1  read strobe, one cycle per byte
//  dma_bus_write_en out 1  write strobe, one cycle per byte
//  dma_busy       out  1   state != S_IDLE
//  dma_done       out  1   one-cycle pulse on normal completion
//  dma_err        out  1   one-cycle pulse on timeout or abort
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE, page/idx/data/timer 0.
//  States: S_IDLE, S_HALT_REQ, S_RD_REQ, S_RD_WAIT, S_RD_LATCH, S_WR, S_DONE.
//  S_IDLE: if snoop_wr_en && snoop_addr==TRIG_ADDR: page<=snoop_data, idx<=0, cpu_halt<=1, timer<=0, ->S_HALT_REQ.
//  S_HALT_REQ: cpu_is_halted && !ext_hold -> S_RD_REQ; else timer++; timer==HALT_TIMEOUT -> dma_err, halt 0, ->S_IDLE.
//  S_RD_REQ: addr={page,idx}, read_en=1 -> S_RD_WAIT (read_en=0) -> S_RD_LATCH (data<=dma_bus_data_in).
//  S_WR: addr=OAM_DATA_ADDR, data_out=data, write_en=1; idx==XFER_LEN-1 -> S_DONE else idx++, ->S_RD_REQ.
//  S_DONE: strobes 0, cpu_halt<=0, dma_done=1 for one cycle -> S_IDLE.
//  Timing: 4 cycles/byte; first read strobe 2 cycles after trigger if CPU already halted;
//   dma_done 1026 cycles after trigger for 256 bytes with no stalls.
//  dma_mux_ctrl = state in {RD_REQ,RD_WAIT,RD_LATCH,WR} && !ext_hold && cpu_is_halted.
//  Strobes and dma_mux_ctrl are forced 0 combinationally whenever ext_hold=1 or cpu_is_halted=0.
//  Stall: ext_hold=1 or cpu_is_halted=0 in any copy state freezes FSM, idx and data.
//   On release, RD_WAIT/RD_LATCH restart at S_RD_REQ (re-read same idx); S_WR re-issues the write.
//  Trigger writes while dma_busy=1 are ignored, including DMA's own $2004 writes.
//  idx is 8 bits; the final byte is detected by compare, never by wrap. Page 8'hFF is legal.
//  dma_abort (any busy state): strobes 0, cpu_halt 0, dma_err pulse, ->S_IDLE next cycle; ignored in S_IDLE.
//  Trigger and abort in the same cycle in S_IDLE: trigger wins.
//  Async reset mid-transfer: immediate return to reset values; no partial completion pulse.
// STRUCTURE
//  Shared package nes_bus_pkg: TRIG_ADDR/OAM_DATA_ADDR localparams and the state encoding
//   (8-bit, matching state_out debug width).
//  Single module; no sub-module needed. The timer is an internal counter, $clog2(HALT_TIMEOUT+1) bits.
// TESTING
//  1. Write 8'h02 to $4014, cpu_is_halted tied 1, memory $0200+i=i^8'hA5:
//     256 writes to $2004 with data i^8'hA5, in order; dma_done at trigger+1026.
//  2. cpu_is_halted rises 10 cycles after cpu_halt: first read_en exactly 1 cycle after halted rises.
//  3. ext_hold pulsed 20 cycles during S_RD_WAIT of idx 7: no strobes while held;
//     $0207 is re-read; total write count stays 256.
//  4. cpu_is_halted never asserted: dma_err at trigger+HALT_TIMEOUT+1; cpu_halt=0; no strobes.
//  5. Second $4014 write mid-transfer, page 8'hFF, then dma_abort at idx 100:
//     the second write is ignored; abort gives dma_err, exactly 100 writes, halt released.
//  6. rst low at idx 50: all outputs 0 asynchronously; after release a new trigger restarts from idx 0.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: fixed register addresses and the sprite-DMA state encoding.
package nes_bus_pkg;

  localparam logic [15:0] TRIG_ADDR     = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  // 8-bit encoding so the state can be exposed on an 8-bit debug bus unchanged.
  typedef enum logic [7:0] {
    StIdle    = 8'd0,
    StHaltReq = 8'd1,
    StRdReq   = 8'd2,
    StRdWait  = 8'd3,
    StRdLatch = 8'd4,
    StWr      = 8'd5,
    StDone    = 8'd6
  } dma_state_e;

  function automatic logic is_copy_state(input dma_state_e s);
    return (s == StRdReq) || (s == StRdWait) || (s == StRdLatch) || (s == StWr);
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// NES sprite DMA sequencer: snoops the $4014 trigger, halts the CPU and copies one page to OAM
// through $2004 as read/write pairs, yielding to the system controller whenever it holds the bus.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter int unsigned XferLen     = 256,
  parameter int unsigned HaltTimeout = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] snoop_addr_i,
  input  logic [7:0]  snoop_data_i,
  input  logic        snoop_wr_en_i,
  input  logic        cpu_is_halted_i,
  input  logic        ext_hold_i,
  input  logic        dma_abort_i,
  input  logic [7:0]  dma_bus_data_in_i,
  output logic        cpu_halt_o,
  output logic        dma_mux_ctrl_o,
  output logic [15:0] dma_bus_addr_o,
  output logic [7:0]  dma_bus_data_out_o,
  output logic        dma_bus_read_en_o,
  output logic        dma_bus_write_en_o,
  output logic        dma_busy_o,
  output logic        dma_done_o,
  output logic        dma_err_o
);

  localparam int unsigned TimerW = $clog2(HaltTimeout + 1);
  localparam logic [7:0] LastIdx = 8'(XferLen - 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(HaltTimeout);

  dma_state_e        state_q, state_d;
  logic [7:0]        page_q, page_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              halt_q, halt_d;

  logic stall;
  logic trig;
  logic rd_en, wr_en;

  assign stall = ext_hold_i || !cpu_is_halted_i;
  assign trig  = snoop_wr_en_i && (snoop_addr_i == TRIG_ADDR);

  always_comb begin
    state_d            = state_q;
    page_d             = page_q;
    idx_d              = idx_q;
    data_d             = data_q;
    timer_d            = timer_q;
    halt_d             = halt_q;
    rd_en              = 1'b0;
    wr_en              = 1'b0;
    dma_bus_addr_o     = 16'h0000;
    dma_bus_data_out_o = 8'h00;
    dma_done_o         = 1'b0;
    dma_err_o          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trig) begin
          page_d  = snoop_data_i;
          idx_d   = 8'd0;
          timer_d = '0;
          halt_d  = 1'b1;
          state_d = StHaltReq;
        end
      end
      StHaltReq: begin
        if (!stall) begin
          state_d = StRdReq;
        end else if (timer_q == TimerMax) begin
          dma_err_o = 1'b1;
          halt_d    = 1'b0;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRdReq: begin
        dma_bus_addr_o = {page_q, idx_q};
        rd_en          = 1'b1;
        if (!stall) state_d = StRdWait;
      end
      StRdWait: begin
        dma_bus_addr_o = {page_q, idx_q};
        // A stall mid-read loses the bus cycle, so the byte is fetched again from scratch.
        state_d        = stall ? StRdReq : StRdLatch;
      end
      StRdLatch: begin
        dma_bus_addr_o = {page_q, idx_q};
        if (stall) begin
          state_d = StRdReq;
        end else begin
          data_d  = dma_bus_data_in_i;
          state_d = StWr;
        end
      end
      StWr: begin
        dma_bus_addr_o     = OAM_DATA_ADDR;
        dma_bus_data_out_o = data_q;
        wr_en              = 1'b1;
        if (!stall) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StRdReq;
          end
        end
      end
      StDone: begin
        dma_done_o = 1'b1;
        halt_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (dma_abort_i && (state_q != StIdle)) begin
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      dma_done_o = 1'b0;
      dma_err_o  = 1'b1;
      halt_d     = 1'b0;
      state_d    = StIdle;
    end
  end

  assign dma_bus_read_en_o  = rd_en && !stall;
  assign dma_bus_write_en_o = wr_en && !stall;
  assign dma_mux_ctrl_o     = is_copy_state(state_q) && !stall;
  assign dma_busy_o         = (state_q != StIdle);
  assign cpu_halt_o         = halt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      timer_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      halt_q  <= halt_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: table of whole-transfer scenarios plus hand-built stall,
// abort, retrigger and mid-transfer reset sequences, checked against a bus monitor.
module tb_oam_dma_ctrl;
  import nes_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] snoop_addr = 16'h0000;
  logic [7:0]  snoop_data = 8'h00;
  logic        snoop_wr_en = 1'b0;
  logic        cpu_is_halted = 1'b0;
  logic        ext_hold = 1'b0;
  logic        dma_abort = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        cpu_halt, dma_mux_ctrl, rd_en, wr_en, dma_busy, dma_done, dma_err;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;

  always #5 clk = ~clk;

  oam_dma_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .snoop_addr_i       (snoop_addr),
    .snoop_data_i       (snoop_data),
    .snoop_wr_en_i      (snoop_wr_en),
    .cpu_is_halted_i    (cpu_is_halted),
    .ext_hold_i         (ext_hold),
    .dma_abort_i        (dma_abort),
    .dma_bus_data_in_i  (rdata),
    .cpu_halt_o         (cpu_halt),
    .dma_mux_ctrl_o     (dma_mux_ctrl),
    .dma_bus_addr_o     (bus_addr),
    .dma_bus_data_out_o (bus_wdata),
    .dma_bus_read_en_o  (rd_en),
    .dma_bus_write_en_o (wr_en),
    .dma_busy_o         (dma_busy),
    .dma_done_o         (dma_done),
    .dma_err_o          (dma_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU model: lat 0 = always halted, lat > 0 = halts lat cycles after cpu_halt, lat < 0 = never.
  int lat = 0;
  int hcnt = 0;
  always @(posedge clk) begin
    #1;
    if (cpu_halt) hcnt = hcnt + 1;
    else hcnt = 0;
    cpu_is_halted = (lat == 0) || ((lat > 0) && (hcnt > lat));
  end

  // Memory: byte at {page, i} is i ^ A5, returned the cycle after the read strobe.
  always @(negedge clk) if (rd_en) rdata <= bus_addr[7:0] ^ 8'hA5;

  logic [7:0] exp_page = 8'h00;
  logic       mon_clr = 1'b0;
  int wr_cnt = 0, rd7 = 0, first_rd = -1, end_cyc = -1, err_seen = 0, done_seen = 0;
  int bad_addr = 0, bad_data = 0, viol = 0;

  always @(negedge clk) begin
    if (mon_clr) begin
      wr_cnt <= 0; rd7 <= 0; first_rd <= -1; end_cyc <= -1; err_seen <= 0; done_seen <= 0;
      bad_addr <= 0; bad_data <= 0; viol <= 0;
    end else begin
      if ((ext_hold || !cpu_is_halted) && (rd_en || wr_en || dma_mux_ctrl)) viol <= viol + 1;
      if (rd_en) begin
        if (first_rd < 0) first_rd <= cyc;
        if (bus_addr != {exp_page, 8'(wr_cnt)} || !dma_mux_ctrl) bad_addr <= bad_addr + 1;
        if (bus_addr[7:0] == 8'd7) rd7 <= rd7 + 1;
      end
      if (wr_en) begin
        if (bus_addr != OAM_DATA_ADDR || !dma_mux_ctrl) bad_addr <= bad_addr + 1;
        if (bus_wdata != (8'(wr_cnt) ^ 8'hA5)) bad_data <= bad_data + 1;
        wr_cnt <= wr_cnt + 1;
      end
      if (dma_done) begin
        done_seen <= done_seen + 1;
        if (end_cyc < 0) end_cyc <= cyc;
      end
      if (dma_err) begin
        err_seen <= err_seen + 1;
        if (end_cyc < 0) end_cyc <= cyc;
      end
    end
  end

  int nvec = 0, nfail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nfail = nfail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon_reset();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  task automatic trigger(input logic [7:0] pg, output int t0);
    snoop_addr  = TRIG_ADDR;
    snoop_data  = pg;
    snoop_wr_en = 1'b1;
    t0          = cyc;
    tick(1);
    snoop_addr  = 16'h0000;
    snoop_data  = 8'h00;
    snoop_wr_en = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (end_cyc >= 0) break;
      tick(1);
    end
    chk({name, "_ended"}, longint'(end_cyc >= 0), 1);
  endtask

  // Waits (bounded) for a read strobe at addr, then steps into the following cycle.
  task automatic wait_read(input string name, input logic [15:0] addr);
    bit found = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (rd_en && bus_addr == addr) begin
        found = 1'b1;
        break;
      end
    end
    chk({name, "_read_seen"}, longint'(found), 1);
    @(posedge clk);
    #1;
  endtask

  function automatic longint outs();
    return longint'({cpu_halt, dma_mux_ctrl, bus_addr, bus_wdata, rd_en, wr_en, dma_busy,
                     dma_done, dma_err});
  endfunction

  typedef struct {
    logic [7:0] page;
    int         lat;
    int         exp_first;
    int         exp_end;
    int         exp_err;
    int         exp_wr;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int t0;
    lat      = v.lat;
    exp_page = v.page;
    tick(2);
    mon_reset();
    trigger(v.page, t0);
    wait_end(tag, 1500);
    tick(3);
    chk({tag, "_first_rd"}, (first_rd < 0) ? -1 : first_rd - t0, v.exp_first);
    chk({tag, "_end_cycle"}, end_cyc - t0, v.exp_end);
    chk({tag, "_err"}, err_seen, v.exp_err);
    chk({tag, "_done"}, done_seen, 1 - v.exp_err);
    chk({tag, "_writes"}, wr_cnt, v.exp_wr);
    chk({tag, "_bad_addr"}, bad_addr, 0);
    chk({tag, "_bad_data"}, bad_data, 0);
    chk({tag, "_strobe_viol"}, viol, 0);
    chk({tag, "_halt_released"}, cpu_halt, 0);
    chk({tag, "_idle"}, dma_busy, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int t0, a_cyc;
    vecs[0] = '{8'h02, 0, 2, 1026, 0, 256};
    vecs[1] = '{8'hFF, 0, 2, 1026, 0, 256};
    vecs[2] = '{8'h02, 10, 12, 1036, 0, 256};
    vecs[3] = '{8'h5A, 5, 7, 1031, 0, 256};
    vecs[4] = '{8'h02, -1, -1, 1024, 1, 0};

    tick(2);
    chk("reset_outputs", outs(), 0);
    rst = 1'b1;
    tick(2);
    chk("idle_outputs", outs(), 0);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Bus held by the system controller during RD_WAIT of idx 7.
    lat = 0; exp_page = 8'h02; tick(2); mon_reset();
    trigger(8'h02, t0);
    wait_read("hold", 16'h0207);
    ext_hold = 1'b1;
    tick(20);
    ext_hold = 1'b0;
    wait_end("hold", 1500);
    tick(2);
    chk("hold_reread_207", rd7, 2);
    chk("hold_writes", wr_cnt, 256);
    chk("hold_strobe_viol", viol, 0);
    chk("hold_bad_data", bad_data, 0);
    chk("hold_end_cycle", end_cyc - t0, 1047);

    // Retrigger with page FF is ignored; abort at idx 100.
    tick(2); mon_reset();
    trigger(8'h02, t0);
    tick(10);
    trigger(8'hFF, a_cyc);
    wait_read("abort", 16'h0264);
    dma_abort = 1'b1;
    a_cyc = cyc;
    tick(1);
    dma_abort = 1'b0;
    tick(3);
    chk("abort_err", err_seen, 1);
    chk("abort_no_done", done_seen, 0);
    chk("abort_err_cycle", end_cyc, a_cyc);
    chk("abort_writes", wr_cnt, 100);
    chk("abort_bad_addr", bad_addr, 0);
    chk("abort_halt_released", cpu_halt, 0);
    chk("abort_idle", dma_busy, 0);

    // Trigger and abort together in idle: trigger wins.
    tick(2); mon_reset();
    dma_abort = 1'b1;
    trigger(8'h02, t0);
    dma_abort = 1'b0;
    chk("trig_wins_busy", dma_busy, 1);
    chk("trig_wins_halt", cpu_halt, 1);
    chk("trig_wins_no_err", err_seen, 0);
    dma_abort = 1'b1;
    tick(1);
    dma_abort = 1'b0;
    tick(2);
    chk("trig_wins_abort_err", err_seen, 1);
    chk("trig_wins_abort_idle", dma_busy, 0);

    // Asynchronous reset at idx 50, then a fresh transfer must start from idx 0.
    tick(2); mon_reset();
    trigger(8'h02, t0);
    wait_read("rst", 16'h0232);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_outputs", outs(), 0);
    tick(2);
    chk("rst_no_done", done_seen, 0);
    chk("rst_no_err", err_seen, 0);
    rst = 1'b1;
    run_vec('{8'h03, 0, 2, 1026, 0, 256}, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
